// File: rtl/ex_md_unit.sv
// ex_md_unit: iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Divider hardware is built only when EX_MD_DIV_EN is defined.
module ex_md_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall_ex
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);
`ifdef EX_MD_DIV_EN
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef EX_MD_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   mag_q;
  logic              neg_q;
  logic [1:0]        f3_q;

  logic              go;
  logic              res_we;
  logic [XLEN-1:0]   res_d;

  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

`ifdef EX_MD_DIV_EN
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_r;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   div_res;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   early_res;
`endif

  // Operand signedness and magnitudes for the requested op
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (funct3)
      3'd0, 3'd1: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'd2: a_sgn = 1'b1;
      3'd4, 3'd6: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      default: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
    endcase
    a_neg = a_sgn & op_a[XLEN-1];
    b_neg = b_sgn & op_b[XLEN-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;
  end

  // Shift-add step, restoring-divide step and final sign fix-up
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + {1'b0, (acc_q[0] ? mag_q : {XLEN{1'b0}})};
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    prod     = neg_q ? -acc_q : acc_q;
    mul_res  = (f3_q == 2'b00) ? prod[XLEN-1:0]
                               : prod[2*XLEN-1:XLEN];
    acc_d    = mul_step;
`ifdef EX_MD_DIV_EN
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    div_step  = div_diff[XLEN]
              ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    quo = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem = neg_r ? -acc_q[2*XLEN-1:XLEN]
                : acc_q[2*XLEN-1:XLEN];
    div_res  = f3_q[1] ? rem : quo;
    div_zero = (b_q == {XLEN{1'b0}});
    div_ovf  = !f3_q[0] && (a_q == MIN) && (&b_q);
    if (f3_q[1])
      early_res = div_zero ? a_q : {XLEN{1'b0}};
    else
      early_res = div_zero ? {XLEN{1'b1}} : a_q;
    if (state_q == S_DIV)
      acc_d = div_step;
`endif
  end

  // Next state, handshake outputs and result write strobe
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    res_we  = 1'b0;
    res_d   = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          go = 1'b1;
          if (!funct3[2])
            state_d = S_MUL;
`ifdef EX_MD_DIV_EN
          else
            state_d = S_DIV;
`else
          else begin
            state_d = S_DONE;
            res_we  = 1'b1;
          end
`endif
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          res_we  = 1'b1;
          res_d   = mul_res;
        end
      end
`ifdef EX_MD_DIV_EN
      S_DIV: begin
        busy = 1'b1;
        if (div_zero || div_ovf) begin
          state_d = S_DONE;
          res_we  = 1'b1;
          res_d   = early_res;
        end else if (cnt_q == LAST) begin
          state_d = S_DONE;
          res_we  = 1'b1;
          res_d   = div_res;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      res_we  = 1'b0;
    end
  end

  assign stall_ex = (start && (state_q == S_IDLE) && !flush) || busy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Operand latch, iteration counter, accumulator and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      mag_q  <= '0;
      neg_q  <= 1'b0;
      f3_q   <= '0;
      result <= '0;
`ifdef EX_MD_DIV_EN
      a_q    <= '0;
      b_q    <= '0;
      neg_r  <= 1'b0;
`endif
    end else begin
      if (res_we)
        result <= res_d;
      if (go) begin
        cnt_q <= '0;
        f3_q  <= funct3[1:0];
        neg_q <= a_neg ^ b_neg;
        mag_q <= funct3[2] ? mag_b : mag_a;
        acc_q <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
`ifdef EX_MD_DIV_EN
        a_q   <= op_a;
        b_q   <= op_b;
        neg_r <= a_neg;
`endif
      end else if (busy && cnt_q != LAST) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_ex_md_unit.sv
// tb_ex_md_unit: scoreboard bench for ex_md_unit (XLEN=32).
// Divide expectations follow whether EX_MD_DIV_EN is defined.
module tb_ex_md_unit;

  localparam int XLEN = 32;
`ifdef EX_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall_ex;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  ex_md_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .flush(flush),
    .funct3(funct3),
    .op_a(op_a),
    .op_b(op_b),
    .busy(busy),
    .done(done),
    .result(result),
    .stall_ex(stall_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (ovf) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = '0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    if (f[2] && !DIV_EN) r = '0;
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f[2]) return 33;
    if (!DIV_EN) return 0;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0)
        chk("spurious_done", done, 1'b0);
      else
        chk("result", result, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input bit poke);
    int k;
    bit st_ok;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    exp_q.push_back(exp);
    #1 chk("stall_accept", stall_ex, 1'b1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    k = 0;
    st_ok = 1'b1;
    seen = 1'b0;
    while (k < 100 && !seen) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        if (stall_ex || busy) st_ok = 1'b0;
      end else begin
        if (!stall_ex || !busy) st_ok = 1'b0;
        start = poke && (k == 5);
        k++;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("latency", k, lat);
    chk("stall_busy", st_ok, 1'b1);
    @(negedge clk);
    chk("done_width", done, 1'b0);
    last_res = exp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall_ex, 1'b0);
    chk("rst_result", result, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
`ifdef EX_MD_DIV_EN
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 1'b0);
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
`else
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 32'd0, 0, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 32'd0, 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
`endif
    run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);

    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 4 == 0) ? 32'd0 : $urandom;
      if (i % 3 == 1) b = 32'($urandom_range(1, 100));
      run_op(f, a, b, ref_md(f, a, b), ref_lat(f, a, b), 1'b0);
    end

    // Flush in cycle 10 of a multiply
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd3;
    op_b   = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("flush_busy_before", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", busy, 1'b0);
    chk("flush_done", done, 1'b0);
    chk("flush_result", result, last_res);
    repeat (40) @(negedge clk);
    chk("flush_result_hold", result, last_res);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 1'b0);

    // Flush wins over a simultaneous start
    @(negedge clk);
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd9;
    op_b   = 32'd9;
    #1 chk("flush_start_stall", stall_ex, 1'b0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("flush_start_idle", busy, 1'b0);

    // Reset in cycle 5 of an operation
    @(negedge clk);
    start  = 1'b1;
`ifdef EX_MD_DIV_EN
    funct3 = 3'd4;
`else
    funct3 = 3'd0;
`endif
    op_a   = 32'd100;
    op_b   = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_stall", stall_ex, 1'b0);
    chk("rst_mid_result", result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    repeat (40) @(negedge clk);
    chk("rst_mid_hold", result, 32'd0);
`ifdef EX_MD_DIV_EN
    run_op(3'd4, 32'd100, 32'd7, 32'd14, 33, 1'b0);
`else
    run_op(3'd0, 32'd100, 32'd7, 32'd700, 33, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_md_unit.md
EX_MD_UNIT -- requirements
Module: ex_md_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits (any even value >= 8).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin an M-extension operation.
REQ-005 The block SHALL have port flush, input, 1, abort the in-flight operation (pipeline flush or branch taken).
REQ-006 The block SHALL have port funct3, input, 3, selecting MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU for codes 0-7.
REQ-007 The block SHALL have ports op_a and op_b, input, XLEN each, the already-forwarded rs1 and rs2 values.
REQ-008 The block SHALL have port busy, output, 1, operation in progress.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-010 The block SHALL have port result, output, XLEN, operation result.
REQ-011 The block SHALL have port stall_ex, output, 1, freezes IF/ID/EX pipeline registers while high.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, MUL, DIV and DONE.
REQ-013 In IDLE, start with funct3[2]=0 SHALL latch operands and funct3 and move to MUL; start with funct3[2]=1 SHALL move to DIV.
REQ-014 start SHALL be ignored in every state except IDLE.
REQ-015 The MUL path SHALL take operand magnitudes per signedness (MUL/MULH: both signed; MULHSU: a signed, b unsigned; MULHU: both unsigned).
REQ-016 The MUL path SHALL perform one shift-add step per cycle for XLEN cycles and negate the 2*XLEN product when the operand signs differ.
REQ-017 The MUL result SHALL be product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for the MULH variants.
REQ-018 The DIV path SHALL be restoring, one quotient bit per cycle for XLEN cycles.
REQ-019 For signed ops the quotient SHALL take sign a XOR b and the remainder SHALL take the sign of a.
REQ-020 Divide by zero SHALL skip iteration and enter DONE next cycle, giving quotient all ones and remainder = op_a.
REQ-021 Signed overflow (op_a = most-negative, op_b = -1) SHALL skip iteration and give quotient = op_a and remainder = 0.
REQ-022 Iterative latency SHALL be: start sampled at edge 0, done high during the cycle after edge XLEN+1; early-exit cases SHALL raise done after edge 1.
REQ-023 DONE SHALL last exactly one cycle, assert done, and then return to IDLE.
REQ-024 result SHALL be registered, update only on entry to DONE, and hold until the next completed operation.
REQ-025 busy SHALL be high in MUL and DIV.
REQ-026 stall_ex SHALL equal (start AND IDLE AND NOT flush) OR busy, so the requesting instruction is held from the accept cycle and released in the DONE cycle.
REQ-027 flush SHALL return the block to IDLE at the next edge from any state, suppress done, and leave result unchanged.
REQ-028 flush SHALL override a simultaneous start in IDLE, so that no operation is accepted.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, done=0, stall_ex=0 and result=0, and clear the iteration counter and accumulators.
REQ-030 Reset asserted mid-operation SHALL discard the operation, and done SHALL never pulse for it.

Configuration
REQ-031 With macro EX_MD_DIV_EN defined, the divide hardware and REQ-018..021 SHALL be present.
REQ-032 Without EX_MD_DIV_EN, the DIV state and divider logic SHALL be absent.
REQ-033 Without EX_MD_DIV_EN, a start with funct3[2]=1 SHALL enter DONE next cycle with result=0.

Verification (XLEN=32)
REQ-034 The bench SHALL check MUL with op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start, stall_ex high cycles 0-32.
REQ-035 The bench SHALL check MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULH with the same operands -> 0x00000000.
REQ-036 The bench SHALL check DIV with 0xFFFFFFEC / 3 -> 0xFFFFFFFA, and REM with the same operands -> 0xFFFFFFFE.
REQ-037 The bench SHALL check DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done one cycle after start; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM with the same operands -> 0.
REQ-038 The bench SHALL check flush at cycle 10 of MUL -> busy low next cycle, no done, result unchanged, and the following start accepted normally.
REQ-039 The bench SHALL check rst_n low at cycle 5 of DIV -> outputs zero immediately, no done, and a clean restart after release.
